// File: rtl/load_store_unit.sv
// Big-endian load/store initiator: aligned word reads/writes, read-modify-write for sub-word stores.
// Optional byte/half support is enabled by defining LSU_SUBWORD_EN; otherwise only lw/sw are legal.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        op_store;
  logic        err_q;
  logic        reject;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    reject = (address >= 32'(MEM_BYTES));
`ifdef LSU_SUBWORD_EN
    case (mem_op)
      3'b000:  reject = reject;
      3'b001:  reject = reject | address[0];
      3'b011:  reject = reject | (address[1:0] != 2'b00);
      3'b100:  reject = reject | is_store;
      3'b101:  reject = reject | is_store | address[0];
      default: reject = 1'b1;
    endcase
`else
    if (mem_op != 3'b011 || address[1:0] != 2'b00) reject = 1'b1;
`endif
  end

`ifdef LSU_SUBWORD_EN
  logic [2:0]  op;
  logic [1:0]  off;
  logic [15:0] wd;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Offset 0 is the most significant byte.
  always_comb begin
    lane_b = mem_data_in[7:0];
    merged = mem_data_in;
    case (off)
      2'd0:    lane_b = mem_data_in[31:24];
      2'd1:    lane_b = mem_data_in[23:16];
      2'd2:    lane_b = mem_data_in[15:8];
      default: lane_b = mem_data_in[7:0];
    endcase
    lane_h = off[1] ? mem_data_in[15:0] : mem_data_in[31:16];
    case (op[1:0])
      2'b00:   load_val = {{24{lane_b[7] & ~op[2]}}, lane_b};
      2'b01:   load_val = {{16{lane_h[15] & ~op[2]}}, lane_h};
      default: load_val = mem_data_in;
    endcase
    if (op[1:0] == 2'b00) begin
      case (off)
        2'd0:    merged[31:24] = wd[7:0];
        2'd1:    merged[23:16] = wd[7:0];
        2'd2:    merged[15:8]  = wd[7:0];
        default: merged[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      merged[15:0] = wd;
    end else begin
      merged[31:16] = wd;
    end
  end
`else
  always_comb begin
    load_val = mem_data_in;
    merged   = mem_data_in;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (reject)                           state_nxt = S_DONE;
          else if (is_store && mem_op == 3'b011) state_nxt = S_WRITE;
          else                                  state_nxt = S_READ;
        end
      end
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = op_store ? S_WRITE : S_DONE;
      S_WRITE:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_DONE) & err_q;
  assign mem_write = (state == S_WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op_store     <= 1'b0;
      err_q        <= 1'b0;
      rdata        <= 32'd0;
      mem_address  <= 32'd0;
      mem_data_out <= 32'd0;
`ifdef LSU_SUBWORD_EN
      op           <= 3'd0;
      off          <= 2'd0;
      wd           <= 16'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        op_store    <= is_store;
        err_q       <= reject;
        mem_address <= {address[31:2], 2'b00};
        if (is_store && !reject) mem_data_out <= wdata;
`ifdef LSU_SUBWORD_EN
        op          <= mem_op;
        off         <= address[1:0];
        wd          <= wdata[15:0];
`endif
      end
      // Read data is valid during CAPTURE; either finish the load or build the RMW word.
      if (state == S_CAPTURE) begin
        if (op_store) mem_data_out <= merged;
        else          rdata        <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        ready;
  logic        is_store;
  logic [2:0]  mem_op;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        error;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready), .is_store(is_store),
    .mem_op(mem_op), .address(address), .wdata(wdata), .rdata(rdata),
    .done(done), .error(error), .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, plus a backdoor preload port.
  logic [31:0] dmem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  int          wr_count = 0;
  logic [31:0] wr_addr = 0;
  logic [31:0] wr_data = 0;

  always @(posedge clk) begin
    if (pl_en) dmem[pl_addr] <= pl_data;
    else if (mem_write) begin
      dmem[mem_address[5:2]] <= mem_data_out;
      wr_count <= wr_count + 1;
      wr_addr  <= mem_address;
      wr_data  <= mem_data_out;
    end
    mem_data_in <= dmem[mem_address[5:2]];
  end

  // Reference model state
  logic [7:0]  ref_bytes [64];
  logic [31:0] exp_rdata = 32'd0;
  int          checks = 0;
  int          errors = 0;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b = a & ~3;
    return {ref_bytes[b], ref_bytes[b+1], ref_bytes[b+2], ref_bytes[b+3]};
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] op, input logic [31:0] a);
    if (a >= 32'd64) return 1'b0;
    if (!SUBWORD) return (op == 3'b011) && (a % 4 == 0);
    case (op)
      3'b000:  return 1'b1;
      3'b001:  return (a % 2 == 0);
      3'b011:  return (a % 4 == 0);
      3'b100:  return !st;
      3'b101:  return !st && (a % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic preload(input int w, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = 4'(w); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_bytes[4*w+k] = d[31-8*k -: 8];
  endtask

  // Issue one access from a negedge; returns at the negedge after done.
  task automatic do_access(input bit st, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd);
    int lat, n, wr0, a;
    bit ok;
    logic [7:0]  b;
    logic [15:0] h;
    ok  = legal(st, op, addr);
    lat = !ok ? 1 : (st ? ((op == 3'b011) ? 2 : 4) : 3);
    a   = int'(addr[5:0]);
    req = 1'b1; is_store = st; mem_op = op; address = addr; wdata = wd;
    wr0 = wr_count;
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (!done && n < 12) begin @(negedge clk); n++; end
    check_val("latency", 32'(n), 32'(lat));
    check_val("error", {31'd0, error}, {31'd0, !ok});
    if (ok && !st) begin
      b = ref_bytes[a];
      if (op[1:0] != 2'b00 && a < 63) h = {ref_bytes[a], ref_bytes[a+1]};
      else h = 16'd0;
      case (op)
        3'b000:  exp_rdata = 32'(signed'(b));
        3'b100:  exp_rdata = {24'd0, b};
        3'b001:  exp_rdata = 32'(signed'(h));
        3'b101:  exp_rdata = {16'd0, h};
        default: exp_rdata = ref_word(a);
      endcase
    end
    if (ok && st) begin
      case (op)
        3'b000: ref_bytes[a] = wd[7:0];
        3'b001: begin ref_bytes[a] = wd[15:8]; ref_bytes[a+1] = wd[7:0]; end
        default: for (int k = 0; k < 4; k++) ref_bytes[a+k] = wd[31-8*k -: 8];
      endcase
    end
    check_val("rdata", rdata, exp_rdata);
    check_val("write_count", 32'(wr_count - wr0), (ok && st) ? 32'd1 : 32'd0);
    if (ok && st) begin
      check_val("write_addr", wr_addr, {addr[31:2], 2'b00});
      check_val("write_data", wr_data, ref_word(a));
    end
    @(negedge clk);
    check_val("ready_after", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int n, wr0;
    logic [31:0] a, w;
    reset = 1'b1; req = 1'b0; is_store = 1'b0; mem_op = 3'd0; address = 32'd0; wdata = 32'd0;
    pl_en = 1'b0; pl_addr = 4'd0; pl_data = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_error", {31'd0, error}, 32'd0);
    check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_mem_address", mem_address, 32'd0);
    check_val("rst_mem_data_out", mem_data_out, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(2, 32'h8899AABC);
    preload(3, 32'hDEADBEEF);

    do_access(1'b0, 3'b000, 32'd10, 32'd0);
    if (SUBWORD) check_val("lb_10", rdata, 32'hFFFFFFAA);
    do_access(1'b0, 3'b100, 32'd10, 32'd0);
    if (SUBWORD) check_val("lbu_10", rdata, 32'h000000AA);
    do_access(1'b0, 3'b011, 32'd8, 32'd0);
    check_val("lw_8", rdata, 32'h8899AABC);
    do_access(1'b1, 3'b011, 32'd4, 32'h11223344);
    check_val("sw_4_data", wr_data, 32'h11223344);
    do_access(1'b0, 3'b101, 32'd6, 32'd0);
    if (SUBWORD) check_val("lhu_6", rdata, 32'h00003344);
    do_access(1'b1, 3'b000, 32'd13, 32'h00000055);
    if (SUBWORD) check_val("sb_13_data", wr_data, 32'hDE55BEEF);
    do_access(1'b0, 3'b011, 32'd6, 32'd0);
    do_access(1'b1, 3'b001, 32'd3, 32'hCAFE);
    do_access(1'b0, 3'b011, 32'd64, 32'd0);
    do_access(1'b0, 3'b000, 32'd0, 32'd0);
    do_access(1'b0, 3'b011, 32'd0, 32'd0);

    // req held high: second lw only accepted after the first completes
    req = 1'b1; is_store = 1'b0; mem_op = 3'b011; address = 32'd8;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    check_val("held_latency", 32'(n), 32'd3);
    check_val("held_ready_in_done", {31'd0, ready}, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    check_val("held_gap", 32'(n), 32'd4);
    req = 1'b0;
    exp_rdata = ref_word(8);
    check_val("held_rdata", rdata, exp_rdata);
    @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 71));
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3;
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Reset during the write cycle of a store drops it completely
    w = ref_word(20);
    wr0 = wr_count;
    req = 1'b1; is_store = 1'b1; mem_op = 3'b011; address = 32'd20; wdata = ~w;
    @(negedge clk);
    req = 1'b0;
    check_val("rst_mid_wr_before", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("rst_mid_wr_after", {31'd0, mem_write}, 32'd0);
    check_val("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 32'd0;
    n = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done) n++; end
    check_val("rst_mid_no_done", 32'(n), 32'd0);
    check_val("rst_mid_no_write", 32'(wr_count - wr0), 32'd0);
    do_access(1'b0, 3'b011, 32'd20, 32'd0);
    check_val("rst_mid_mem_intact", rdata, w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
